// File: rtl/fp_addsub_align.sv
// fp_addsub_align: multi-cycle floating-point add/subtract front end.
// Unpacks two packed operands, orders them by magnitude, aligns the smaller
// mantissa one bit per cycle with a sticky bit, adds or subtracts, and
// corrects carry-out. Produces the pre-rounding {hidden, frac, G, R, S}
// mantissa. Leading-zero normalization is left to the rounding stage.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            launch an operation (sampled only in IDLE)
//   sub              1 = op_a - op_b, 0 = op_a + op_b
//   op_a, op_b       packed {sign, exp, frac}
//   busy             high from the cycle after accepted start through done
//   done             one-cycle pulse, result outputs valid
//   sign, exponent   result sign and biased exponent
//   mantissa         {hidden, frac, G, R, S}
//   overflow         exponent reached all-ones after carry correction
//   special          an operand had an all-ones exponent (Inf/NaN)
module fp_addsub_align #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic [EXP_W+DATA_W-1:0] op_a,
  input  logic [EXP_W+DATA_W-1:0] op_b,
  output logic                    busy,
  output logic                    done,
  output logic                    sign,
  output logic [EXP_W-1:0]        exponent,
  output logic [DATA_W+2:0]       mantissa,
  output logic                    overflow,
  output logic                    special
);

  localparam int unsigned OPW = EXP_W + DATA_W;   // packed operand width
  localparam int unsigned FW  = DATA_W - 1;       // stored fraction width
  localparam int unsigned MW  = DATA_W + 3;       // mantissa incl. G/R/S
  localparam int unsigned SW  = DATA_W + 4;       // sum incl. carry-out
  localparam int unsigned CW  = $clog2(MW + 1);   // shift counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    NORM  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [EXP_W-1:0]  ea_q, ea_d;
  logic [MW-1:0]     ma_q, ma_d;
  logic [MW-1:0]     mb_q, mb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic              sign_big_q, sign_big_d;
  logic              eff_sub_q, eff_sub_d;
  logic              zero_sign_q, zero_sign_d;
  logic              spec_op_q, spec_op_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MW-1:0]     mant_q, mant_d;
  logic              ovf_q, ovf_d;
  logic              special_q, special_d;

  // Operand unpack: zero exponent flushes to a zero mantissa
  logic              sa_c, sb_eff_c;
  logic [EXP_W-1:0]  ea_raw_c, eb_raw_c;
  logic [MW-1:0]     ma_raw_c, mb_raw_c;
  logic              swap_c;
  logic [EXP_W-1:0]  e_big_c, e_small_c, diff_c;
  logic [CW-1:0]     cnt_init_c;
  logic [EXP_W-1:0]  exp_inc_c;

  assign sa_c     = op_a[OPW-1];
  assign sb_eff_c = op_b[OPW-1] ^ sub;
  assign ea_raw_c = op_a[OPW-2 -: EXP_W];
  assign eb_raw_c = op_b[OPW-2 -: EXP_W];
  assign ma_raw_c = (ea_raw_c == '0) ? '0 : {1'b1, op_a[FW-1:0], 3'b000};
  assign mb_raw_c = (eb_raw_c == '0) ? '0 : {1'b1, op_b[FW-1:0], 3'b000};

  // Strictly-larger B swaps; equal magnitudes keep A first
  assign swap_c     = {eb_raw_c, mb_raw_c} > {ea_raw_c, ma_raw_c};
  assign e_big_c    = swap_c ? eb_raw_c : ea_raw_c;
  assign e_small_c  = swap_c ? ea_raw_c : eb_raw_c;
  assign diff_c     = e_big_c - e_small_c;
  assign cnt_init_c = (diff_c > EXP_W'(MW)) ? CW'(MW) : CW'(diff_c);

  assign exp_inc_c  = ea_q + EXP_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ea_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sign_big_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      zero_sign_q <= 1'b0;
      spec_op_q   <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      ovf_q       <= 1'b0;
      special_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ea_q        <= ea_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sign_big_q  <= sign_big_d;
      eff_sub_q   <= eff_sub_d;
      zero_sign_q <= zero_sign_d;
      spec_op_q   <= spec_op_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      ovf_q       <= ovf_d;
      special_q   <= special_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ea_d        = ea_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sign_big_d  = sign_big_q;
    eff_sub_d   = eff_sub_q;
    zero_sign_d = zero_sign_q;
    spec_op_d   = spec_op_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    ovf_d       = ovf_q;
    special_d   = special_q;

    case (state_q)
      IDLE: begin
        // busy drops after done unless a new op is accepted in the done cycle
        busy_d = start;
        if (start) begin
          ea_d        = e_big_c;
          ma_d        = swap_c ? mb_raw_c : ma_raw_c;
          mb_d        = swap_c ? ma_raw_c : mb_raw_c;
          cnt_d       = cnt_init_c;
          sign_big_d  = swap_c ? sb_eff_c : sa_c;
          eff_sub_d   = sa_c ^ sb_eff_c;
          zero_sign_d = sa_c & sb_eff_c;
          spec_op_d   = (&ea_raw_c) | (&eb_raw_c);
          state_d     = ALIGN;
        end
      end

      ALIGN: begin
        if (cnt_q == '0) begin
          state_d = ADD;
        end else begin
          // Shift right by one, folding the dropped bit into the sticky LSB
          mb_d  = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
          cnt_d = cnt_q - CW'(1);
        end
      end

      ADD: begin
        // Ordering guarantees ma >= mb, so the difference is never negative
        if (eff_sub_q) begin
          sum_d = {1'b0, ma_q} - {1'b0, mb_q};
        end else begin
          sum_d = {1'b0, ma_q} + {1'b0, mb_q};
        end
        state_d = NORM;
      end

      NORM: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (spec_op_q) begin
          sign_d    = 1'b0;
          exp_d     = '1;
          mant_d    = '0;
          ovf_d     = 1'b0;
          special_d = 1'b1;
        end else if (sum_q == '0) begin
          sign_d    = zero_sign_q;
          exp_d     = '0;
          mant_d    = '0;
          ovf_d     = 1'b0;
          special_d = 1'b0;
        end else if (sum_q[SW-1]) begin
          // Carry-out: shift right once, keeping the sticky information
          sign_d    = sign_big_q;
          exp_d     = exp_inc_c;
          mant_d    = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
          ovf_d     = &exp_inc_c;
          special_d = 1'b0;
        end else begin
          sign_d    = sign_big_q;
          exp_d     = ea_q;
          mant_d    = sum_q[MW-1:0];
          ovf_d     = 1'b0;
          special_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sign     = sign_q;
  assign exponent = exp_q;
  assign mantissa = mant_q;
  assign overflow = ovf_q;
  assign special  = special_q;

endmodule

// File: tb/tb_fp_addsub_align.sv
// Self-checking bench for fp_addsub_align: directed cases plus randomized
// operands checked against a magnitude-level arithmetic reference model.
module tb_fp_addsub_align;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MW     = DATA_W + 3;
  localparam int unsigned OPW    = EXP_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              sub;
  logic [OPW-1:0]    op_a;
  logic [OPW-1:0]    op_b;
  logic              busy;
  logic              done;
  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic [MW-1:0]     mantissa;
  logic              overflow;
  logic              special;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             sign;
    logic [EXP_W-1:0] e;
    logic [MW-1:0]    m;
    logic             ovf;
    logic             spc;
    int               lat;
  } res_t;

  fp_addsub_align #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .exponent (exponent),
    .mantissa (mantissa),
    .overflow (overflow),
    .special  (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: real-number style align with jamming sticky, then add/sub
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   r;
    longint ea, eb, ma, mb, d, ebig, mbig, msml, shifted, sum, lost;
    logic   sa, sbe, sbig;
    ea  = longint'(a[30:23]);
    eb  = longint'(b[30:23]);
    ma  = (ea == 0) ? 0 : (longint'({1'b1, a[22:0]}) << 3);
    mb  = (eb == 0) ? 0 : (longint'({1'b1, b[22:0]}) << 3);
    sa  = a[31];
    sbe = b[31] ^ s;
    d   = (ea > eb) ? ea - eb : eb - ea;
    if (d > 27) d = 27;
    r.lat = 3 + int'(d);
    r.ovf = 1'b0;
    r.spc = 1'b0;
    if (ea == 255 || eb == 255) begin
      r.spc = 1'b1; r.sign = 1'b0; r.e = 8'hFF; r.m = '0;
      return r;
    end
    if (((eb << 27) + mb) > ((ea << 27) + ma)) begin
      ebig = eb; mbig = mb; msml = ma; sbig = sbe;
    end else begin
      ebig = ea; mbig = ma; msml = mb; sbig = sa;
    end
    lost    = msml & ((64'sd1 <<< d) - 1);
    shifted = (msml >> d) | ((lost != 0) ? 64'sd1 : 64'sd0);
    sum     = (sa ^ sbe) ? mbig - shifted : mbig + shifted;
    if (sum == 0) begin
      r.sign = sa & sbe; r.e = '0; r.m = '0;
    end else if (sum >= (64'sd1 << 27)) begin
      r.sign = sbig;
      r.e    = 8'(ebig + 1);
      r.m    = 27'((sum >> 1) | (sum & 1));
      r.ovf  = (ebig + 1 == 255);
    end else begin
      r.sign = sbig; r.e = 8'(ebig); r.m = 27'(sum);
    end
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic s, input int unsigned e, input logic [22:0] f);
    return {s, 8'(e), f};
  endfunction

  // Launch one op, wait for done within a bound, check latency and result
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    res_t r;
    int   n;
    r = model(a, b, s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
    chk({tag, ".busy_start"}, 64'(busy), 64'(1));
    chk({tag, ".done_early"}, 64'(done), 64'(0));
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".done_seen"}, 64'(done), 64'(1));
    chk({tag, ".latency"}, 64'(n), 64'(r.lat));
    chk({tag, ".busy_done"}, 64'(busy), 64'(1));
    chk({tag, ".sign"}, 64'(sign), 64'(r.sign));
    chk({tag, ".exp"}, 64'(exponent), 64'(r.e));
    chk({tag, ".mant"}, 64'(mantissa), 64'(r.m));
    chk({tag, ".ovf"}, 64'(overflow), 64'(r.ovf));
    chk({tag, ".spc"}, 64'(special), 64'(r.spc));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".sign"}, 64'(sign), 64'(0));
    chk({tag, ".exp"}, 64'(exponent), 64'(0));
    chk({tag, ".mant"}, 64'(mantissa), 64'(0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(0));
    chk({tag, ".spc"}, 64'(special), 64'(0));
  endtask

  initial begin
    res_t        r;
    int          ndone;
    logic [31:0] a, b;
    int unsigned ea, eb;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived constants
    run_op(32'h3F800000, 32'h3F800000, 1'b0, "carry");
    chk("carry.k_exp", 64'(exponent), 64'd128);
    chk("carry.k_mant", 64'(mantissa), 64'h4000000);
    run_op(32'h3FC00000, 32'h3F400000, 1'b0, "align1");
    chk("align1.k_exp", 64'(exponent), 64'd128);
    chk("align1.k_mant", 64'(mantissa), 64'h4800000);
    run_op(32'h3F800000, 32'h30800000, 1'b0, "clamp");
    chk("clamp.k_exp", 64'(exponent), 64'd127);
    chk("clamp.k_mant", 64'(mantissa), 64'h4000001);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, "cancel");
    chk("cancel.k_exp", 64'(exponent), 64'd0);
    chk("cancel.k_sign", 64'(sign), 64'd0);
    run_op(32'hBF800000, 32'h80000000, 1'b0, "negzero");
    chk("negzero.k_sign", 64'(sign), 64'd1);
    chk("negzero.k_exp", 64'(exponent), 64'd127);
    chk("negzero.k_mant", 64'(mantissa), 64'h4000000);
    run_op(32'h80000000, 32'h00000000, 1'b1, "bothneg0");
    chk("bothneg0.k_sign", 64'(sign), 64'd1);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, "ovf");
    chk("ovf.k_exp", 64'(exponent), 64'd255);
    chk("ovf.k_ovf", 64'(overflow), 64'd1);
    run_op(32'h7F800000, 32'h3F800000, 1'b0, "special");
    chk("special.k_spc", 64'(special), 64'd1);
    chk("special.k_mant", 64'(mantissa), 64'd0);
    run_op(32'h3F800000, 32'h40000000, 1'b1, "bigb");
    chk("bigb.k_sign", 64'(sign), 64'd1);

    // Start pulsed mid-ALIGN must be ignored
    r = model(32'h3F800000, 32'h3A800000, 1'b0);
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h3A800000; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op_a = 32'h40000000; op_b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk("ign.exp", 64'(exponent), 64'(r.e));
        chk("ign.mant", 64'(mantissa), 64'(r.m));
        chk("ign.sign", 64'(sign), 64'(r.sign));
      end
    end
    chk("ign.ndone", 64'(ndone), 64'd1);

    // Reset asserted mid-ALIGN aborts without a done
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h35800000; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst.ndone", 64'(ndone), 64'd0);
    run_op(32'h3FC00000, 32'h3F400000, 1'b1, "after_rst");

    // Randomized operands, mostly with nearby exponents
    for (int i = 0; i < 60; i++) begin
      ea = $urandom_range(1, 254);
      case ($urandom_range(0, 9))
        0:       eb = 0;
        1:       eb = 255;
        2:       eb = $urandom_range(1, 254);
        3:       eb = ea;
        default: eb = (ea + $urandom_range(0, 40) > 20) ? ea + $urandom_range(0, 40) - 20 : 1;
      endcase
      if (eb > 255) eb = 254;
      a = mk(1'($urandom), ea, 23'($urandom));
      b = mk(1'($urandom), eb, 23'($urandom));
      if (eb == ea && $urandom_range(0, 3) == 0) b[22:0] = a[22:0];
      if ($urandom_range(0, 1) == 1) begin
        run_op(b, a, 1'($urandom), $sformatf("rnd%0d", i));
      end else begin
        run_op(a, b, 1'($urandom), $sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_align.md
# fp_addsub_align

Multi-cycle floating-point add/subtract front end. Produces the pre-rounding result that the round-to-nearest-even stage consumes.
- Unpacks two packed operands and orders them by magnitude.
- Aligns the smaller mantissa one bit per cycle, accumulating a sticky bit.
- Adds or subtracts, then corrects carry-out.
- Emits sign, exponent and a DATA_W+3-bit mantissa with guard/round/sticky LSBs.

Leading-zero normalization is left to the rounding stage.

## Interface
- DATA_W, 24, mantissa width including hidden bit
- EXP_W, 8, exponent width (bias 2^(EXP_W-1)-1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch operation; sampled only in IDLE
- sub  in  1  1 = op_a - op_b, 0 = op_a + op_b
- op_a  in  EXP_W+DATA_W  packed {sign, exp, frac[DATA_W-2:0]}
- op_b  in  EXP_W+DATA_W  same format
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse: outputs valid
- sign  out  1  result sign
- exponent  out  EXP_W  biased result exponent
- mantissa  out  DATA_W+3  {hidden, frac, G, R, S}; bit DATA_W+2 = hidden position
- overflow  out  1  exponent reached all-ones after carry correction
- special  out  1  an operand had exp all-ones (Inf/NaN, unsupported)

## Operation
- States: IDLE, ALIGN, ADD, NORM.
- **IDLE, start=1:**
  - Unpack: exp==0 → operand is zero (mantissa 0, denormals flushed); else m = {1, frac, 3'b000}.
  - Effective sign of B = sb^sub.
  - Swap so A has the larger {exp, m} (tie: no swap).
  - Register ea, ma, mb, diff = ea-eb.
  - cnt = min(diff, DATA_W+3).
  - eff_sub = sa ^ sb ^ sub. Result sign = sign of A; B's effective sign is used when B is the larger operand.
  - Go to ALIGN.
- **ALIGN:**
  - If cnt == 0 → ADD.
  - Else mb = {0, mb[DATA_W+2:2], mb[1]|mb[0]}, cnt--.
  - After DATA_W+3 shifts, mb reduces to sticky only.
- **ADD:** sum[DATA_W+3:0] = ma + mb (eff_sub=0) or ma - mb (eff_sub=1; never negative due to ordering). Go to NORM.
- **NORM:**
  - If sum[DATA_W+3]: mantissa = {sum[DATA_W+3:2], sum[1]|sum[0]}, exponent = ea+1. overflow=1 if ea+1 is all-ones.
  - Else mantissa = sum[DATA_W+2:0], exponent = ea.
  - If sum == 0: exponent = 0, mantissa = 0, sign = sa & (sb^sub). This yields +0 unless both effective signs are negative.
  - Assert done, go to IDLE.
- **special:** if either exp is all-ones, special=1, exponent = all-ones, mantissa = 0, sign = 0. Timing still passes through all states, so latency is unchanged.
- Outputs (sign, exponent, mantissa, overflow, special) are registered and held until the next NORM.
- start in any state other than IDLE is ignored; op_a, op_b and sub need only be stable in the start cycle.

## Timing
- **Reset** (asynchronous, rst_n=0): state IDLE, busy=0, done=0, sign=0, exponent=0, mantissa=0, overflow=0, special=0, cnt=0. Takes effect immediately and aborts any operation in flight; no done is produced for it.
- **Latency:** start sampled at edge T → done high in the cycle after edge T+3+d, where d = min(diff, DATA_W+3).
  - Minimum 4 cycles (diff=0).
  - Maximum DATA_W+7 = 31 cycles.
- **Back-to-back:** start may be asserted in the done cycle. The FSM is in IDLE then, so the new operation is accepted. busy stays high for the new operation without dropping.
- done and busy are both high in the done cycle.

## Test plan
- **Reset / sum with carry:** reset, then start with 0x3F800000 + 0x3F800000 (sub=0) → done in cycle T+4; sign=0, exponent=128, mantissa=0x4000000, overflow=0.
- **1-bit alignment:** 0x3FC00000 + 0x3F400000 → diff=1; done at T+5; exponent=128, mantissa=0x4800000.
- **Clamped shift / sticky:** 0x3F800000 + 0x30800000 → diff=30, clamped to 27; done at T+31; exponent=127, mantissa=0x4000001 (sticky set).
- **Exact cancellation:** 0x3F800000 - 0x3F800000 → sign=0, exponent=0, mantissa=0. Then 0xBF800000 + 0x80000000 → sign=1, exponent=127, mantissa=0x4000000.
- **Overflow / special:** 0x7F7FFFFF + 0x7F7FFFFF → exponent=255, overflow=1. 0x7F800000 + 0x3F800000 → special=1, exponent=255, mantissa=0.
- **Ignored start / reset mid-ALIGN:**
  - start pulsed during ALIGN of a diff=10 operation → ignored; original result unchanged, single done.
  - rst_n pulled low mid-ALIGN → all outputs 0 immediately, no done; next start completes normally.
